// File: rtl/i2s_tx_stream_if.sv
// Sample-pair stream into the I2S serialiser: one stereo pair per valid/ready beat.
interface i2s_tx_stream_if #(
    parameter int SAMPLE_W = 16
);
    logic                s_valid;
    logic                s_ready;
    logic [SAMPLE_W-1:0] s_left;
    logic [SAMPLE_W-1:0] s_right;

    modport master (output s_valid, output s_left, output s_right, input s_ready);
    modport slave  (input s_valid, input s_left, input s_right, output s_ready);
endinterface

// File: rtl/i2s_tx_stream.sv
// I2S / left-justified stereo serialiser with a one-pair holding buffer and underrun flagging.
// Optional macro I2S_TX_UNDERRUN_CNT_EN adds a saturating 16-bit underrun counter port.
module i2s_tx_stream #(
    parameter int SAMPLE_W = 16,
    parameter int SLOT_W   = 16,
    parameter int BCK_DIV  = 4,
    parameter int FORMAT   = 0
) (
    input  logic           clk,
    input  logic           arst_n,
    i2s_tx_stream_if.slave s,
    output logic           i2s_bck,
    output logic           i2s_lrck,
    output logic           i2s_din,
    output logic           frame_strobe,
    output logic           underrun
`ifdef I2S_TX_UNDERRUN_CNT_EN
    ,
    output logic [15:0]    underrun_cnt
`endif
);
    localparam int FRAME_W = 2 * SLOT_W;
    localparam int BC_W    = $clog2(FRAME_W);
    localparam int DIV_W   = (BCK_DIV > 1) ? $clog2(BCK_DIV) : 1;
    localparam int PAD_W   = SLOT_W - SAMPLE_W;

    typedef logic [SLOT_W-1:0]  slot_t;
    typedef logic [FRAME_W-1:0] frame_t;

    generate
        if (SAMPLE_W < 8 || SAMPLE_W > 32) begin : g_bad_sample_w
            $error("i2s_tx_stream: SAMPLE_W must be 8..32");
        end
        if (SLOT_W < SAMPLE_W || SLOT_W > 64) begin : g_bad_slot_w
            $error("i2s_tx_stream: SLOT_W must be SAMPLE_W..64");
        end
        if (BCK_DIV < 1) begin : g_bad_bck_div
            $error("i2s_tx_stream: BCK_DIV must be >= 1");
        end
    endgenerate

    logic [DIV_W-1:0]    div_q, div_d;
    logic [BC_W-1:0]     bit_cnt_q, bit_cnt_d;
    logic                bck_q, bck_d;
    logic                lrck_q, lrck_d;
    logic                din_q, din_d;
    logic                dly_q, dly_d;
    frame_t              frame_q, frame_d;
    logic                strobe_q, strobe_d;
    logic                und_q, und_d;
    logic                full_q, full_d;
    logic [SAMPLE_W-1:0] buf_left_q, buf_right_q;

    logic   tick, shift, boundary, accept, cur_bit;
    frame_t load_val;

    assign tick     = (div_q == DIV_W'(BCK_DIV - 1));
    assign shift    = tick & bck_q;
    assign boundary = shift & (bit_cnt_q == BC_W'(FRAME_W - 1));
    assign accept   = s.s_valid & ~full_q;
    // An empty buffer at the boundary mutes the whole frame rather than replaying stale data.
    assign load_val = full_q ? {slot_t'(buf_left_q) << PAD_W, slot_t'(buf_right_q) << PAD_W}
                             : '0;

    // NOTE: every signal assigned in an always_comb gets a default first, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        div_d     = tick ? '0 : div_q + 1'b1;
        bck_d     = tick ? ~bck_q : bck_q;
        bit_cnt_d = bit_cnt_q;
        lrck_d    = lrck_q;
        din_d     = din_q;
        dly_d     = dly_q;
        frame_d   = frame_q;
        cur_bit   = 1'b0;
        strobe_d  = boundary;
        und_d     = boundary & ~full_q;
        full_d    = full_q;

        if (shift) begin
            if (boundary) begin
                bit_cnt_d = '0;
                frame_d   = load_val;
                cur_bit   = load_val[FRAME_W-1];
            end else begin
                bit_cnt_d = bit_cnt_q + 1'b1;
                frame_d   = frame_q << 1;
                cur_bit   = frame_q[FRAME_W-2];
            end
            lrck_d = (bit_cnt_d >= BC_W'(SLOT_W));
            // I2S sends the bit held from the previous shift; LJ sends the current one.
            dly_d  = cur_bit;
            din_d  = (FORMAT != 0) ? cur_bit : dly_q;
        end

        if (boundary) full_d = 1'b0;
        if (accept)   full_d = 1'b1;
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            div_q     <= '0;
            bck_q     <= 1'b0;
            bit_cnt_q <= BC_W'(FRAME_W - 1);
            lrck_q    <= 1'b0;
            din_q     <= 1'b0;
            dly_q     <= 1'b0;
            frame_q   <= '0;
            strobe_q  <= 1'b0;
            und_q     <= 1'b0;
            full_q    <= 1'b0;
        end else begin
            div_q     <= div_d;
            bck_q     <= bck_d;
            bit_cnt_q <= bit_cnt_d;
            lrck_q    <= lrck_d;
            din_q     <= din_d;
            dly_q     <= dly_d;
            frame_q   <= frame_d;
            strobe_q  <= strobe_d;
            und_q     <= und_d;
            full_q    <= full_d;
        end
    end

    // NOTE: the sample buffer has no reset; its contents are only consumed while full_q is set, which reset clears.
    always_ff @(posedge clk) begin
        if (accept) begin
            buf_left_q  <= s.s_left;
            buf_right_q <= s.s_right;
        end
    end

`ifdef I2S_TX_UNDERRUN_CNT_EN
    logic [15:0] ucnt_q;

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            ucnt_q <= '0;
        end else if (und_d && ucnt_q != 16'hFFFF) begin
            ucnt_q <= ucnt_q + 16'd1;
        end
    end

    assign underrun_cnt = ucnt_q;
`endif

    assign s.s_ready    = ~full_q;
    assign i2s_bck      = bck_q;
    assign i2s_lrck     = lrck_q;
    assign i2s_din      = din_q;
    assign frame_strobe = strobe_q;
    assign underrun     = und_q;
endmodule

// File: tb/tb_i2s_tx_stream.sv
// Randomised bench for i2s_tx_stream: three configurations driven in lockstep and checked against a time-arithmetic model.
module tb_i2s_tx_stream;
    localparam int BD    = 2;
    localparam int NDUT  = 3;
    localparam int NFRM  = 64;
    localparam int SLOT [NDUT] = '{16, 16, 24};
    localparam int FMT  [NDUT] = '{0, 1, 0};

    logic        clk;
    logic        arst_n;
    logic        tb_valid;
    logic [15:0] tb_left, tb_right;

    logic bck_o [NDUT];
    logic lrck_o [NDUT];
    logic din_o [NDUT];
    logic stb_o [NDUT];
    logic und_o [NDUT];
    logic rdy_o [NDUT];
`ifdef I2S_TX_UNDERRUN_CNT_EN
    logic [15:0] cnt_o [NDUT];
`endif

    i2s_tx_stream_if #(.SAMPLE_W(16)) if_a ();
    i2s_tx_stream_if #(.SAMPLE_W(16)) if_b ();
    i2s_tx_stream_if #(.SAMPLE_W(16)) if_c ();

    assign if_a.s_valid = tb_valid; assign if_a.s_left = tb_left; assign if_a.s_right = tb_right;
    assign if_b.s_valid = tb_valid; assign if_b.s_left = tb_left; assign if_b.s_right = tb_right;
    assign if_c.s_valid = tb_valid; assign if_c.s_left = tb_left; assign if_c.s_right = tb_right;
    assign rdy_o[0] = if_a.s_ready;
    assign rdy_o[1] = if_b.s_ready;
    assign rdy_o[2] = if_c.s_ready;

    i2s_tx_stream #(.SAMPLE_W(16), .SLOT_W(16), .BCK_DIV(BD), .FORMAT(0)) u_i2s16 (
        .clk(clk), .arst_n(arst_n), .s(if_a.slave),
        .i2s_bck(bck_o[0]), .i2s_lrck(lrck_o[0]), .i2s_din(din_o[0]),
        .frame_strobe(stb_o[0]), .underrun(und_o[0])
`ifdef I2S_TX_UNDERRUN_CNT_EN
        , .underrun_cnt(cnt_o[0])
`endif
    );

    i2s_tx_stream #(.SAMPLE_W(16), .SLOT_W(16), .BCK_DIV(BD), .FORMAT(1)) u_lj16 (
        .clk(clk), .arst_n(arst_n), .s(if_b.slave),
        .i2s_bck(bck_o[1]), .i2s_lrck(lrck_o[1]), .i2s_din(din_o[1]),
        .frame_strobe(stb_o[1]), .underrun(und_o[1])
`ifdef I2S_TX_UNDERRUN_CNT_EN
        , .underrun_cnt(cnt_o[1])
`endif
    );

    i2s_tx_stream #(.SAMPLE_W(16), .SLOT_W(24), .BCK_DIV(BD), .FORMAT(0)) u_i2s24 (
        .clk(clk), .arst_n(arst_n), .s(if_c.slave),
        .i2s_bck(bck_o[2]), .i2s_lrck(lrck_o[2]), .i2s_din(din_o[2]),
        .frame_strobe(stb_o[2]), .underrun(und_o[2])
`ifdef I2S_TX_UNDERRUN_CNT_EN
        , .underrun_cnt(cnt_o[2])
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: t counts clk edges since reset release; frames[] holds what each frame must carry.
    int          n_tests;
    int          n_fail;
    int          t;
    logic [47:0] frames [NDUT][NFRM];
    bit          und_f  [NDUT][NFRM];
    bit          m_full [NDUT];
    logic [15:0] m_l    [NDUT];
    logic [15:0] m_r    [NDUT];
    int          m_cnt  [NDUT];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s t=%0d: got %0h expected %0h", tag, t, got, exp);
        end
    endtask

    function automatic bit is_boundary(input int d, input int tt);
        int n;
        n = tt / (2 * BD);
        return (tt > 0) && (tt % (2 * BD) == 0) && ((n - 1) % (2 * SLOT[d]) == 0);
    endfunction

    function automatic logic frame_bit(input int d, input int g);
        int fw, f, b;
        logic [47:0] fr;
        fw = 2 * SLOT[d];
        f  = g / fw;
        b  = g % fw;
        if (f >= NFRM) return 1'b0;
        fr = frames[d][f];
        return fr[fw - 1 - b];
    endfunction

    task automatic model_clear();
        for (int d = 0; d < NDUT; d++) begin
            for (int f = 0; f < NFRM; f++) begin
                frames[d][f] = '0;
                und_f[d][f]  = 1'b0;
            end
            m_full[d] = 1'b0;
            m_cnt[d]  = 0;
        end
        t = 0;
    endtask

    // Apply the effect of the next rising edge given the inputs currently driven.
    task automatic model_advance();
        int tt, f;
        bit acc;
        tt = t + 1;
        for (int d = 0; d < NDUT; d++) begin
            acc = tb_valid && !m_full[d];
            if (is_boundary(d, tt)) begin
                f = (tt / (2 * BD) - 1) / (2 * SLOT[d]);
                if (f < NFRM) begin
                    frames[d][f] = m_full[d] ? ((48'(m_l[d]) << (2 * SLOT[d] - 16)) |
                                                (48'(m_r[d]) << (SLOT[d] - 16)))
                                             : 48'h0;
                    und_f[d][f]  = !m_full[d];
                end
                if (!m_full[d] && m_cnt[d] < 16'hFFFF) m_cnt[d]++;
                m_full[d] = 1'b0;
            end
            if (acc) begin
                m_l[d]    = tb_left;
                m_r[d]    = tb_right;
                m_full[d] = 1'b1;
            end
        end
        t = tt;
    endtask

    task automatic check_all();
        int n, fw, bc, e_lrck, e_din, e_stb, e_und;
        for (int d = 0; d < NDUT; d++) begin
            n  = t / (2 * BD);
            fw = 2 * SLOT[d];
            e_lrck = 0;
            e_din  = 0;
            if (n > 0) begin
                bc     = (n - 1) % fw;
                e_lrck = (bc >= SLOT[d]) ? 1 : 0;
                if (FMT[d] != 0) e_din = frame_bit(d, n - 1);
                else if (n >= 2) e_din = frame_bit(d, n - 2);
            end
            e_stb = is_boundary(d, t) ? 1 : 0;
            e_und = 0;
            if (e_stb != 0 && (n - 1) / fw < NFRM) e_und = und_f[d][(n - 1) / fw] ? 1 : 0;
            check($sformatf("bck%0d", d),   32'(bck_o[d]),  32'((t / BD) % 2));
            check($sformatf("lrck%0d", d),  32'(lrck_o[d]), 32'(e_lrck));
            check($sformatf("din%0d", d),   32'(din_o[d]),  32'(e_din));
            check($sformatf("strobe%0d", d), 32'(stb_o[d]), 32'(e_stb));
            check($sformatf("underrun%0d", d), 32'(und_o[d]), 32'(e_und));
            check($sformatf("ready%0d", d), 32'(rdy_o[d]),  32'(!m_full[d]));
`ifdef I2S_TX_UNDERRUN_CNT_EN
            check($sformatf("ucnt%0d", d),  32'(cnt_o[d]),  32'(m_cnt[d]));
`endif
        end
    endtask

    task automatic check_reset(input string tag);
        for (int d = 0; d < NDUT; d++) begin
            check($sformatf("%s_bck%0d", tag, d),    32'(bck_o[d]),  32'd0);
            check($sformatf("%s_lrck%0d", tag, d),   32'(lrck_o[d]), 32'd0);
            check($sformatf("%s_din%0d", tag, d),    32'(din_o[d]),  32'd0);
            check($sformatf("%s_strobe%0d", tag, d), 32'(stb_o[d]), 32'd0);
            check($sformatf("%s_under%0d", tag, d),  32'(und_o[d]),  32'd0);
            check($sformatf("%s_ready%0d", tag, d),  32'(rdy_o[d]),  32'd1);
`ifdef I2S_TX_UNDERRUN_CNT_EN
            check($sformatf("%s_ucnt%0d", tag, d),   32'(cnt_o[d]),  32'd0);
`endif
        end
    endtask

    // Inputs are already driven; advance model and DUT one clk and compare on the falling edge.
    task automatic step();
        model_advance();
        @(posedge clk);
        @(negedge clk);
        check_all();
    endtask

    task automatic rand_data();
        tb_left  = 16'($urandom);
        tb_right = 16'($urandom);
    endtask

    initial begin
        n_tests  = 0;
        n_fail   = 0;
        arst_n   = 1'b0;
        tb_valid = 1'b0;
        tb_left  = '0;
        tb_right = '0;
        model_clear();
        repeat (3) @(negedge clk);
        check_reset("rst");

        arst_n   = 1'b1;
        tb_valid = 1'b1;
        tb_left  = 16'hA5F0;
        tb_right = 16'h0F81;
        step();

        for (int i = 0; i < 1500; i++) begin
            tb_valid = ($urandom_range(0, 3) == 0);
            rand_data();
            step();
        end

        for (int i = 0; i < 600; i++) begin
            tb_valid = 1'b1;
            rand_data();
            step();
        end

        #2 arst_n = 1'b0;
        #1 check_reset("midrst");
        model_clear();
        tb_valid = 1'b0;
        @(negedge clk);
        check_reset("hold");
        arst_n = 1'b1;

        for (int i = 0; i < 8; i++) step();

        for (int i = 0; i < 1500; i++) begin
            tb_valid = ($urandom_range(0, 1) == 0);
            rand_data();
            step();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
